// File: rtl/ccff_chain_loader_if.sv
// Host-side byte handshake into the configuration chain loader.
// The host drives data_in/data_valid; the loader returns data_ready.
interface ccff_chain_loader_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_in, output data_valid, input  data_ready);
    modport slave  (input  data_in, input  data_valid, output data_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises host bytes MSB-first into a CHAIN_LEN-bit config chain; 1 bit per enabled cycle, >=1 cycle FETCH bubble per byte.
// Host is backpressured via data_ready (high only in FETCH); build with CCFF_LOADER_READBACK_EN to count ccff_tail readback mismatches.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 24,
    parameter int CNT_W     = 16
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset_n,
    input  logic                 start,
    ccff_chain_loader_if.slave   host,
    output logic                 ccff_head,
    output logic                 ccff_clk_en,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     mismatch_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_shreg, w_shreg_nxt;
    logic [3:0]       r_sub,   w_sub_nxt;
    logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic             r_head, w_head_nxt;
    logic             r_en,   w_en_nxt;
    logic             r_busy, r_done;
    logic             w_pass_start;

    assign w_pass_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Head/enable registers hold the bit being shifted *this* cycle, so they
    // are loaded on the edge that enters (or stays in) SHIFT.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_sub_nxt     = r_sub;
        w_bit_cnt_nxt = r_bit_cnt;
        w_head_nxt    = 1'b0;
        w_en_nxt      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt   = S_FETCH;
                    w_bit_cnt_nxt = '0;
                end
            end
            S_FETCH: begin
                if (host.data_valid) begin
                    w_state_nxt   = S_SHIFT;
                    w_head_nxt    = host.data_in[7];
                    w_shreg_nxt   = {host.data_in[6:0], 1'b0};
                    w_sub_nxt     = 4'd1;
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    w_en_nxt      = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_bit_cnt == LEN) begin
                    w_state_nxt = S_DONE;
                end else if (r_sub == 4'd8) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_head_nxt    = r_shreg[7];
                    w_shreg_nxt   = {r_shreg[6:0], 1'b0};
                    w_sub_nxt     = r_sub + 4'd1;
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    w_en_nxt      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_sub     <= '0;
            r_bit_cnt <= '0;
            r_head    <= 1'b0;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_sub     <= w_sub_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_head    <= w_head_nxt;
            r_en      <= w_en_nxt;
            r_busy    <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_SHIFT);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    assign host.data_ready = (r_state == S_FETCH);
    assign ccff_head       = r_head;
    assign ccff_clk_en     = r_en;
    assign busy            = r_busy;
    assign done            = r_done;

`ifdef CCFF_LOADER_READBACK_EN
    logic             r_prev_loaded;
    logic [CNT_W-1:0] r_mm_cnt;

    // A re-sent identical stream makes the tail bit equal the head bit at the same index.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_prev_loaded <= 1'b0;
            r_mm_cnt      <= '0;
        end else begin
            if (w_pass_start) begin
                r_mm_cnt <= '0;
            end else if (r_en && r_prev_loaded && (r_head != ccff_tail) && (r_mm_cnt != '1)) begin
                r_mm_cnt <= r_mm_cnt + CNT_W'(1);
            end
            if ((r_state == S_SHIFT) && (w_state_nxt == S_DONE)) begin
                r_prev_loaded <= 1'b1;
            end
        end
    end

    assign mismatch_cnt = r_mm_cnt;
`else
    logic w_unused_tail;
    logic w_unused_start;
    assign w_unused_tail  = ccff_tail;
    assign w_unused_start = w_pass_start;
    assign mismatch_cnt   = '0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench: drivers queue expected head bits per accepted byte, monitors pop on every enabled cycle.
module tb_ccff_chain_loader;

`ifdef CCFF_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic        rst_n;
    logic        start_a, start_b;
    logic        head_a, en_a, busy_a, done_a, tail_a;
    logic        head_b, en_b, busy_b, done_b, tail_b;
    logic [15:0] mm_a, mm_b;
    logic [23:0] chain_a = '0;

    ccff_chain_loader_if if_a ();
    ccff_chain_loader_if if_b ();

    // 24-bit chain model so the tail returns what was shifted in 24 enables ago
    always @(posedge prog_clk) if (en_a) chain_a <= {chain_a[22:0], head_a};
    assign tail_a = chain_a[23];
    assign tail_b = 1'b0;

    ccff_chain_loader #(.CHAIN_LEN(24), .CNT_W(16)) dut_a (
        .prog_clk(prog_clk), .prog_reset_n(rst_n), .start(start_a), .host(if_a),
        .ccff_head(head_a), .ccff_clk_en(en_a), .ccff_tail(tail_a),
        .busy(busy_a), .done(done_a), .mismatch_cnt(mm_a));

    ccff_chain_loader #(.CHAIN_LEN(20), .CNT_W(16)) dut_b (
        .prog_clk(prog_clk), .prog_reset_n(rst_n), .start(start_b), .host(if_b),
        .ccff_head(head_b), .ccff_clk_en(en_b), .ccff_tail(tail_b),
        .busy(busy_b), .done(done_b), .mismatch_cnt(mm_b));

    int n_vec = 0;
    int n_err = 0;
    bit q_a[$];
    bit q_b[$];
    int en_cnt[2];
    int en0[2];
    int pushed[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    always @(negedge prog_clk) begin
        if (en_a === 1'b1) begin
            en_cnt[0]++;
            if (q_a.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL head_a: got enabled bit %0b required no enabled cycle", head_a);
            end else chk("head_a", 32'(head_a), 32'(q_a.pop_front()));
        end
    end

    always @(negedge prog_clk) begin
        if (en_b === 1'b1) begin
            en_cnt[1]++;
            if (q_b.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL head_b: got enabled bit %0b required no enabled cycle", head_b);
            end else chk("head_b", 32'(head_b), 32'(q_b.pop_front()));
        end
    end

    function automatic logic rdy(input int w);
        return (w != 0) ? if_b.data_ready : if_a.data_ready;
    endfunction

    task automatic start_pass(input int w);
        pushed[w] = 0;
        en0[w]    = en_cnt[w];
        if (w != 0) start_b = 1'b1; else start_a = 1'b1;
        @(negedge prog_clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Called and returns on a negedge; valid is dropped after the accepting edge.
    task automatic send_byte(input int w, input logic [7:0] b);
        int len = (w != 0) ? 20 : 24;
        int t = 0;
        for (int i = 7; i >= 0; i--) begin
            if (pushed[w] < len) begin
                if (w != 0) q_b.push_back(b[i]); else q_a.push_back(b[i]);
                pushed[w]++;
            end
        end
        if (w != 0) begin if_b.data_in = b; if_b.data_valid = 1'b1; end
        else        begin if_a.data_in = b; if_a.data_valid = 1'b1; end
        while (!rdy(w) && t < 300) begin
            @(negedge prog_clk);
            t++;
        end
        if (t >= 300) begin
            n_vec++; n_err++;
            $display("FAIL data_ready_timeout: got ready=0 for %0d cycles required ready", t);
        end
        @(posedge prog_clk);
        @(negedge prog_clk);
        if_a.data_valid = 1'b0;
        if_b.data_valid = 1'b0;
    endtask

    task automatic finish_pass(input int w, input int exp_mm);
        int len = (w != 0) ? 20 : 24;
        int t = 0;
        while (((w != 0) ? done_b : done_a) !== 1'b1 && t < 500) begin
            @(negedge prog_clk);
            t++;
        end
        chk("done", 32'((w != 0) ? done_b : done_a), 32'd1);
        chk("busy_at_done", 32'((w != 0) ? busy_b : busy_a), 32'd0);
        chk("enable_count", 32'(en_cnt[w] - en0[w]), 32'(len));
        chk("queue_left", 32'((w != 0) ? q_b.size() : q_a.size()), 32'd0);
        chk("mismatch_cnt", 32'((w != 0) ? mm_b : mm_a), 32'(exp_mm));
        // Offer a surplus byte: it must never be taken.
        if (w != 0) begin if_b.data_in = 8'hEE; if_b.data_valid = 1'b1; end
        else        begin if_a.data_in = 8'hEE; if_a.data_valid = 1'b1; end
        for (int i = 0; i < 3; i++) begin
            @(negedge prog_clk);
            chk("ready_after_done", 32'(rdy(w)), 32'd0);
        end
        chk("no_extra_shift", 32'(en_cnt[w] - en0[w]), 32'(len));
        if_a.data_valid = 1'b0;
        if_b.data_valid = 1'b0;
    endtask

    task automatic load3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int exp_mm);
        start_pass(0);
        send_byte(0, b0);
        send_byte(0, b1);
        send_byte(0, b2);
        finish_pass(0, exp_mm);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        if_a.data_in = '0; if_a.data_valid = 1'b0;
        if_b.data_in = '0; if_b.data_valid = 1'b0;
        #1;
        chk("rst_head", 32'(head_a), 32'd0);
        chk("rst_en", 32'(en_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_ready", 32'(if_a.data_ready), 32'd0);
        chk("rst_mm", 32'(mm_a), 32'd0);
        @(negedge prog_clk);
        @(negedge prog_clk);
        rst_n = 1'b1;
        @(negedge prog_clk);

        // 20-bit chain: tail of third byte discarded
        start_pass(1);
        send_byte(1, 8'hFF);
        send_byte(1, 8'h00);
        send_byte(1, 8'hF0);
        finish_pass(1, 0);

        // Plain 24-bit load
        load3(8'hA5, 8'h3C, 8'h0F, 0);

        // Backpressure: host idle for 5 cycles while loader waits in FETCH
        start_pass(0);
        send_byte(0, 8'hA5);
        t = 0;
        while (!if_a.data_ready && t < 50) begin @(negedge prog_clk); t++; end
        for (int i = 0; i < 5; i++) begin
            chk("stall_en", 32'(en_a), 32'd0);
            chk("stall_ready", 32'(if_a.data_ready), 32'd1);
            @(negedge prog_clk);
        end
        send_byte(0, 8'h3C);
        send_byte(0, 8'h0F);
        finish_pass(0, 0);

        // Reset after 10 enabled bits
        start_pass(0);
        send_byte(0, 8'hA5);
        send_byte(0, 8'h3C);
        t = 0;
        while ((en_cnt[0] - en0[0]) < 10 && t < 100) begin @(negedge prog_clk); t++; end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(en_a), 32'd0);
        chk("mid_rst_head", 32'(head_a), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_done", 32'(done_a), 32'd0);
        chk("mid_rst_ready", 32'(if_a.data_ready), 32'd0);
        q_a.delete();
        @(negedge prog_clk);
        rst_n = 1'b1;
        @(negedge prog_clk);
        load3(8'hA5, 8'h3C, 8'h0F, 0);

        // Readback: identical reload, then a one-bit change in the first byte
        load3(8'hA5, 8'h3C, 8'h0F, 0);
        load3(8'hA4, 8'h3C, 8'h0F, RB ? 1 : 0);

        // start pulse during SHIFT is ignored
        start_pass(0);
        send_byte(0, 8'hA5);
        chk("shift_en_before_start", 32'(en_a), 32'd1);
        start_a = 1'b1;
        @(negedge prog_clk);
        start_a = 1'b0;
        chk("busy_after_start_in_shift", 32'(busy_a), 32'd1);
        send_byte(0, 8'h3C);
        send_byte(0, 8'h0F);
        finish_pass(0, RB ? 1 : 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
